// File: rtl/floating_point_vec_stream.sv
// floating_point_vec_stream
//   Streams a fixed table of IEEE-754 test vectors (single or double precision)
//   out of an AXI-Stream style master port. Each accepted start emits table
//   entries 0..DEPTH-1 in order. The table read is registered. A two-entry
//   output/skid stage sits behind it, so a sink holding tready high receives
//   one beat per cycle.
//
//   Optional build macro: FLT_VEC_STREAM_LOOP_EN
//     defined   : after the last beat the pass restarts at entry 0 by itself,
//                 until rst (busy stays high, done pulses once per pass)
//     undefined : one pass per start
//
// Parameters
//   EXP_WIDTH  exponent width (8 single, 11 double)
//   MAN_WIDTH  mantissa width (23 single, 52 double)
//   DEPTH      vectors per pass, 1..16
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   start          one-cycle pass request (ignored while busy)
//   busy           pass in progress
//   done           one-cycle pulse after the last beat transfers
//   m_axis_tvalid  beat valid
//   m_axis_tready  sink ready
//   m_axis_tdata   vector value {sign, exponent, mantissa}
//   m_axis_tlast   marks beat DEPTH-1
//   m_axis_tuser   {is_nan, is_inf, is_zero} of m_axis_tdata
//
// FSM states
//   state | meaning
//   IDLE  | waiting for start, nothing in flight
//   RUN   | pass active, last beat not yet on the output
//   LAST  | beat DEPTH-1 is on the output, waiting for it to transfer

module floating_point_vec_stream #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int DEPTH     = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic [2:0]                     m_axis_tuser
);

  localparam int         W        = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam bit         DBL      = (EXP_WIDTH == 11);
  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

`ifdef FLT_VEC_STREAM_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] seed(input int k);
    logic [31:0] s;
    case (k)
      0:       s = 32'h12153524;
      1:       s = 32'hC0895E81;
      2:       s = 32'h8484D609;
      3:       s = 32'hB1F05663;
      4:       s = 32'h06B97B0D;
      5:       s = 32'h46DF998D;
      6:       s = 32'hB2C28465;
      default: s = 32'h00000000;
    endcase
    return s;
  endfunction

  function automatic logic [W-1:0] tbl_entry(input logic [3:0] idx);
    logic [W-1:0] v;
    int           k;
    k = int'(idx);
    case (idx)
      4'd7:  v = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
      4'd8:  v = {1'b0, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      4'd9:  v = '0;
      4'd10: v = {1'b1, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      4'd11: v = W'(1);
      4'd12, 4'd13, 4'd14, 4'd15:
             v = W'({2{32'h89375212}});
      default: begin
        // Double entries pair seed k with seed k+3 (mod 7) in the low word.
        if (DBL) v = W'({seed(k), seed((k + 3) % 7)});
        else     v = W'(seed(k));
      end
    endcase
    return v;
  endfunction

  function automatic logic [2:0] classify(input logic [W-1:0] v);
    logic [EXP_WIDTH-1:0] e;
    logic [MAN_WIDTH-1:0] m;
    logic                 e_ones, e_zero, m_zero;
    e      = v[W-2 -: EXP_WIDTH];
    m      = v[MAN_WIDTH-1:0];
    e_ones = &e;
    e_zero = ~|e;
    m_zero = ~|m;
    return {e_ones & ~m_zero, e_ones & m_zero, e_zero & m_zero};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t       state;
  logic [3:0]   addr;
  logic         fetching;

  // registered table read
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         rd_last;
  logic [2:0]   rd_user;

  // second entry behind the output register
  logic         sk_valid;
  logic [W-1:0] sk_data;
  logic         sk_last;
  logic [2:0]   sk_user;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  logic         accept;
  logic         pop;
  logic         head_free;
  logic         head_load_last;
  logic [2:0]   occ_after;
  logic         credit;
  logic         fetch_go;
  logic [3:0]   fetch_addr;
  logic         fetch_is_last;
  logic [W-1:0] tbl_data;

  always_comb begin
    accept    = (state == IDLE) & start;
    pop       = m_axis_tvalid & m_axis_tready;
    head_free = ~m_axis_tvalid | m_axis_tready;

    // Items held after this edge (output, skid, read stage all move forward).
    // A new read is issued only if the output and skid entries can still
    // absorb it next cycle even if the sink stalls.
    occ_after = {2'b00, m_axis_tvalid} + {2'b00, sk_valid} + {2'b00, rd_valid}
              - {2'b00, pop};
    credit    = (occ_after <= 3'd1);

    // Start always finds the pipeline empty, so the first read needs no credit.
    fetch_go      = accept | (fetching & credit);
    fetch_addr    = accept ? 4'd0 : addr;
    fetch_is_last = (fetch_addr == LAST_IDX);
    tbl_data      = tbl_entry(fetch_addr);

    // The beat about to be loaded into the output register is the pass's last.
    head_load_last = head_free & (sk_valid ? sk_last : (rd_valid & rd_last));
  end

  // ---------------------------------------------------------------------------
  // Table read and output/skid datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      fetching      <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      rd_last       <= 1'b0;
      rd_user       <= '0;
      sk_valid      <= 1'b0;
      sk_data       <= '0;
      sk_last       <= 1'b0;
      sk_user       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      if (fetch_go) begin
        rd_valid <= 1'b1;
        rd_data  <= tbl_data;
        rd_last  <= fetch_is_last;
        rd_user  <= classify(tbl_data);
        addr     <= fetch_is_last ? 4'd0 : fetch_addr + 4'd1;
        fetching <= fetch_is_last ? LOOP_EN : 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end

      if (head_free) begin
        if (sk_valid) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= sk_data;
          m_axis_tlast  <= sk_last;
          m_axis_tuser  <= sk_user;
          sk_valid      <= rd_valid;
          if (rd_valid) begin
            sk_data <= rd_data;
            sk_last <= rd_last;
            sk_user <= rd_user;
          end
        end else begin
          m_axis_tvalid <= rd_valid;
          if (rd_valid) begin
            m_axis_tdata <= rd_data;
            m_axis_tlast <= rd_last;
            m_axis_tuser <= rd_user;
          end
        end
      end else if (rd_valid) begin
        // Output stalled: the read in flight parks in the skid entry.
        sk_valid <= 1'b1;
        sk_data  <= rd_data;
        sk_last  <= rd_last;
        sk_user  <= rd_user;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pass sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (head_load_last) state <= LAST;
        end
        LAST: begin
          if (pop) begin
            done <= 1'b1;
            // In loop mode with DEPTH=1 the next pass's last beat can replace
            // the one leaving in the same edge.
            if (LOOP_EN && head_load_last) begin
              state <= LAST;
            end else if (LOOP_EN) begin
              state <= RUN;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
